// File: rtl/controlador_display_if.sv
// Write port of the display scan controller: new digit values plus blank mask,
// with ready acting as the back-pressure signal while a commit is pending.
interface controlador_display_if #(
  parameter int unsigned N_DIGITOS = 4
) ();
  logic                     wr_en;
  logic [4*N_DIGITOS-1:0]   wr_valor;
  logic [N_DIGITOS-1:0]     wr_blank;
  logic                     ready;

  modport master (
    output wr_en,
    output wr_valor,
    output wr_blank,
    input  ready
  );

  modport slave (
    input  wr_en,
    input  wr_valor,
    input  wr_blank,
    output ready
  );
endinterface

// File: rtl/controlador_display.sv
// Time-multiplexed scan controller for an N-digit common-anode 7-segment display.
// Values written through the port are held in a shadow copy and committed only at frame end.
module controlador_display #(
  parameter int unsigned N_DIGITOS   = 4,
  parameter int unsigned DIV_REFRESH = 50000
) (
  input  logic                         clk,
  input  logic                         reset,
  controlador_display_if.slave         wr,
  output logic [3:0]                   nibble_out,
  output logic [N_DIGITOS-1:0]         anodo_out,
  output logic [$clog2(N_DIGITOS)-1:0] digito_idx
);

  localparam int unsigned IdxW = $clog2(N_DIGITOS);
  localparam int unsigned CntW = (DIV_REFRESH > 1) ? $clog2(DIV_REFRESH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DIV_REFRESH - 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(N_DIGITOS - 1);

  typedef enum logic {StGuard, StAtivo} fase_e;

  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [IdxW-1:0]        idx_q, idx_d;
  fase_e                  fase_q, fase_d;
  logic [4*N_DIGITOS-1:0] sh_valor_q, sh_valor_d;
  logic [N_DIGITOS-1:0]   sh_blank_q, sh_blank_d;
  logic [4*N_DIGITOS-1:0] disp_valor_q, disp_valor_d;
  logic [N_DIGITOS-1:0]   disp_blank_q, disp_blank_d;
  logic                   pend_q, pend_d;
  logic [3:0]             nibble_q, nibble_d;
  logic [N_DIGITOS-1:0]   anodo_q, anodo_d;

  logic fim_slot, fronteira, commit, aceita;

  always_comb begin
    fim_slot  = (cnt_q == CntLast);
    fronteira = fim_slot && (idx_q == IdxLast);
    commit    = fronteira && pend_q;
    // A pending write blocks new ones, so accept and commit never coincide.
    aceita    = wr.wr_en && !pend_q;

    cnt_d = fim_slot ? '0 : cnt_q + 1'b1;
    idx_d = idx_q;
    if (fim_slot) begin
      idx_d = (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
    end
    fase_d = (cnt_d == '0) ? StGuard : StAtivo;

    sh_valor_d   = sh_valor_q;
    sh_blank_d   = sh_blank_q;
    disp_valor_d = disp_valor_q;
    disp_blank_d = disp_blank_q;
    pend_d       = pend_q;
    if (commit) begin
      disp_valor_d = sh_valor_q;
      disp_blank_d = sh_blank_q;
      pend_d       = 1'b0;
    end else if (aceita) begin
      sh_valor_d = wr.wr_valor;
      sh_blank_d = wr.wr_blank;
      pend_d     = 1'b1;
    end

    // Outputs are precomputed from next state so they leave the FSM registered.
    nibble_d = disp_valor_d[{idx_d, 2'b00} +: 4];
    anodo_d  = '1;
    if (fase_d == StAtivo && !disp_blank_d[idx_d]) begin
      anodo_d[idx_d] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      fase_q       <= StGuard;
      sh_valor_q   <= '0;
      sh_blank_q   <= '0;
      disp_valor_q <= '0;
      disp_blank_q <= '0;
      pend_q       <= 1'b0;
      nibble_q     <= '0;
      anodo_q      <= '1;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      fase_q       <= fase_d;
      sh_valor_q   <= sh_valor_d;
      sh_blank_q   <= sh_blank_d;
      disp_valor_q <= disp_valor_d;
      disp_blank_q <= disp_blank_d;
      pend_q       <= pend_d;
      nibble_q     <= nibble_d;
      anodo_q      <= anodo_d;
    end
  end

  assign wr.ready   = ~pend_q;
  assign nibble_out = nibble_q;
  assign anodo_out  = anodo_q;
  assign digito_idx = idx_q;

  logic unused_fase;
  assign unused_fase = (fase_q == StAtivo);

endmodule

// File: tb/tb_controlador_display.sv
// Randomized and directed bench for controlador_display against a cycle-count
// reference model (slot/digit derived from elapsed cycles since reset).
module tb_controlador_display;
  localparam int unsigned N   = 4;
  localparam int unsigned DIV = 4;

  logic       clk;
  logic       reset;
  logic [3:0] nibble_out;
  logic [N-1:0] anodo_out;
  logic [1:0] digito_idx;

  controlador_display_if #(.N_DIGITOS(N)) wr_if ();

  controlador_display #(
    .N_DIGITOS  (N),
    .DIV_REFRESH(DIV)
  ) u_dut (
    .clk       (clk),
    .reset     (reset),
    .wr        (wr_if.slave),
    .nibble_out(nibble_out),
    .anodo_out (anodo_out),
    .digito_idx(digito_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference model state
  int unsigned  m_t;
  logic [15:0]  m_disp_v, m_sh_v;
  logic [3:0]   m_disp_b, m_sh_b;
  logic         m_pend;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_t = 0; m_disp_v = '0; m_sh_v = '0; m_disp_b = '0; m_sh_b = '0; m_pend = 1'b0;
  endtask

  // One clock cycle: check outputs for the current cycle, drive inputs, advance the model.
  task automatic run_cycle(input logic en, input logic [15:0] v, input logic [3:0] b,
                           input logic rst);
    int unsigned slot_pos, dig;
    logic [3:0] exp_an;
    @(negedge clk);
    slot_pos = m_t % DIV;
    dig      = (m_t / DIV) % N;
    exp_an   = 4'hF;
    if (slot_pos != 0 && !m_disp_b[dig]) exp_an[dig] = 1'b0;
    check_eq("anodo", 32'(anodo_out), 32'(exp_an));
    check_eq("nibble", 32'(nibble_out), 32'((m_disp_v >> (4 * dig)) & 16'hF));
    check_eq("idx", 32'(digito_idx), dig);
    check_eq("ready", 32'(wr_if.ready), 32'(!m_pend));

    reset          = rst;
    wr_if.wr_en    = en;
    wr_if.wr_valor = v;
    wr_if.wr_blank = b;

    if (rst) begin
      model_reset();
    end else begin
      if (m_pend && slot_pos == DIV - 1 && dig == N - 1) begin
        m_disp_v = m_sh_v; m_disp_b = m_sh_b; m_pend = 1'b0;
      end else if (en && !m_pend) begin
        m_sh_v = v; m_sh_b = b; m_pend = 1'b1;
      end
      m_t = (m_t + 1) % (N * DIV);
    end
  endtask

  task automatic idle(input int unsigned n);
    for (int i = 0; i < n; i++) run_cycle(1'b0, 16'h0, 4'h0, 1'b0);
  endtask

  task automatic do_reset();
    run_cycle(1'b0, 16'h0, 4'h0, 1'b1);
  endtask

  initial begin
    reset          = 1'b1;
    wr_if.wr_en    = 1'b0;
    wr_if.wr_valor = '0;
    wr_if.wr_blank = '0;
    repeat (2) @(posedge clk);
    model_reset();

    // Reset scan, no writes
    idle(32);

    // Write mid-frame at cycle 6
    do_reset();
    idle(6);
    run_cycle(1'b1, 16'h4321, 4'h0, 1'b0);
    idle(25);

    // Second write while pending is ignored
    do_reset();
    idle(2);
    run_cycle(1'b1, 16'hAAAA, 4'h0, 1'b0);
    idle(2);
    run_cycle(1'b1, 16'hBBBB, 4'h0, 1'b0);
    idle(26);

    // Blank mask
    do_reset();
    run_cycle(1'b1, 16'h00F0, 4'b1010, 1'b0);
    idle(40);

    // Reset with a write pending
    do_reset();
    run_cycle(1'b1, 16'h9999, 4'h0, 1'b0);
    idle(8);
    do_reset();
    idle(20);

    // Write one cycle before the frame boundary
    do_reset();
    idle(14);
    run_cycle(1'b1, 16'h5555, 4'h0, 1'b0);
    idle(8);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      run_cycle(($urandom_range(0, 7) == 0), 16'($urandom), 4'($urandom),
                ($urandom_range(0, 299) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
